// File: rtl/divisor_pkg.sv
// Shared constants for the programmable multi-channel clock divider.
package divisor_pkg;

  localparam int unsigned CntWDef      = 16;
  localparam int unsigned DefPeriodDef = 50;
  localparam int unsigned MinPeriod    = 2;

endpackage

// File: rtl/canal_divisor.sv
// One divider channel: phase counter, active/pending period and registered outputs.
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int unsigned CntW      = CntWDef,
  parameter int unsigned DefPeriod = DefPeriodDef
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            wr_i,
  input  logic [CntW-1:0] wr_period_i,
  output logic            pend_o,
  output logic            clk_out_o,
  output logic            tick_o
);

  logic [CntW-1:0] period_q, period_d;
  logic [CntW-1:0] pend_period_q, pend_period_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            run_q;
  logic            clk_out_q, clk_out_d;
  logic            tick_q, tick_d;
  logic            wrap;

  assign wrap = run_q && (cnt_q == period_q - CntW'(1));

  always_comb begin
    period_d      = period_q;
    pend_period_d = pend_period_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;

    if (!en_i) begin
      cnt_d = '0;
      if (pend_q) begin
        period_d = pend_period_q;
        pend_d   = 1'b0;
      end
    end else if (!run_q) begin
      // First enabled cycle starts a full high phase from cnt = 0.
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      if (pend_q) begin
        period_d = pend_period_q;
        pend_d   = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    // A channel that is not continuing to run has no phase to protect: load directly.
    if (wr_i) begin
      if (en_i && run_q) begin
        pend_period_d = wr_period_i;
        pend_d        = 1'b1;
      end else begin
        period_d = wr_period_i;
      end
    end

    // Outputs registered from next-state values so they line up with cnt_q.
    clk_out_d = en_i && (cnt_d < (period_d >> 1));
    tick_d    = en_i && (cnt_d == period_d - CntW'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q      <= CntW'(DefPeriod);
      pend_period_q <= CntW'(DefPeriod);
      pend_q        <= 1'b0;
      cnt_q         <= '0;
      run_q         <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      period_q      <= period_d;
      pend_period_q <= pend_period_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      run_q         <= en_i;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/divisor_frecuencia_prog.sv
// Programmable N-channel clock divider with a shared configuration write port.
module divisor_frecuencia_prog
  import divisor_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = CntWDef,
  parameter int unsigned DEF_PERIOD = DefPeriodDef,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;
  logic            ch_hit;
  logic            period_ok;
  logic            accept;
  logic            cfg_err_q, cfg_err_d;

  // Out-of-range channels match no entry, leaving cfg_ready at 1.
  always_comb begin
    cfg_ready = 1'b1;
    ch_hit    = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~pend[i];
        ch_hit    = 1'b1;
      end
    end
  end

  assign period_ok = (cfg_period >= CNT_W'(MinPeriod));
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_err_d = accept && !(ch_hit && period_ok);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    assign wr[g] = accept && period_ok && (int'(cfg_ch) == g);

    canal_divisor #(
      .CntW      (CNT_W),
      .DefPeriod (DEF_PERIOD)
    ) u_canal (
      .clk_i       (clk_in),
      .rst_ni      (rst_n),
      .en_i        (en[g]),
      .wr_i        (wr[g]),
      .wr_period_i (cfg_period),
      .pend_o      (pend[g]),
      .clk_out_o   (clk_out[g]),
      .tick_o      (tick[g])
    );
  end

endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Directed self-checking bench for divisor_frecuencia_prog.
module tb_divisor_frecuencia_prog;

  logic        clk_in;
  logic        rst_n;
  logic [3:0]  en;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_ready;
  logic        cfg_err;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  // Three-channel instance so an out-of-range channel number is expressible.
  logic [2:0]  en3;
  logic        cfg3_valid;
  logic [1:0]  cfg3_ch;
  logic [15:0] cfg3_period;
  logic        ready3;
  logic        err3;
  logic [2:0]  clk_out3;
  logic [2:0]  tick3;

  int n_checks = 0;
  int n_fail   = 0;

  divisor_frecuencia_prog #(
    .N_CH       (4),
    .CNT_W      (16),
    .DEF_PERIOD (50)
  ) u_dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  divisor_frecuencia_prog #(
    .N_CH       (3),
    .CNT_W      (16),
    .DEF_PERIOD (50)
  ) u_dut3 (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en3),
    .cfg_valid  (cfg3_valid),
    .cfg_ch     (cfg3_ch),
    .cfg_period (cfg3_period),
    .cfg_ready  (ready3),
    .cfg_err    (err3),
    .clk_out    (clk_out3),
    .tick       (tick3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Checks n cycles of one enabled channel starting at phase 'start'; all others must be idle.
  task automatic run_ch(input int ch, input int p, input int start, input int n);
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
    int c;
    for (int j = 0; j < n; j++) begin
      c        = (start + j) % p;
      exp_clk  = '0;
      exp_tick = '0;
      exp_clk[ch]  = (c < p / 2);
      exp_tick[ch] = (c == p - 1);
      check_eq($sformatf("ch%0d_p%0d_c%0d", ch, p, c), {24'd0, tick, clk_out},
               {24'd0, exp_tick, exp_clk});
      step();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 4'b0000;
    cfg_valid   = 1'b0;
    cfg_ch      = 2'd0;
    cfg_period  = 16'd0;
    en3         = 3'b000;
    cfg3_valid  = 1'b0;
    cfg3_ch     = 2'd0;
    cfg3_period = 16'd10;
    repeat (3) step();

    check_eq("rst_clk_out", {28'd0, clk_out}, 32'd0);
    check_eq("rst_tick", {28'd0, tick}, 32'd0);
    check_eq("rst_err", {31'd0, cfg_err}, 32'd0);
    check_eq("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("rst_clk_out3", {29'd0, clk_out3}, 32'd0);

    // Default period 50 on channel 0.
    rst_n = 1'b1;
    en    = 4'b0001;
    step();
    run_ch(0, 50, 0, 107);

    // New period requested at cnt = 7.
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd0;
    cfg_period = 16'd10;
    #1 check_eq("rdy_idle", {31'd0, cfg_ready}, 32'd1);
    run_ch(0, 50, 7, 1);
    cfg_period = 16'd20;
    #1 check_eq("rdy_pend", {31'd0, cfg_ready}, 32'd0);
    run_ch(0, 50, 8, 1);
    cfg_ch     = 2'd1;
    cfg_period = 16'd8;
    #1 check_eq("rdy_ch1", {31'd0, cfg_ready}, 32'd1);
    run_ch(0, 50, 9, 1);
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    #1 check_eq("rdy_hold", {31'd0, cfg_ready}, 32'd0);
    run_ch(0, 50, 10, 40);
    check_eq("rdy_wrap", {31'd0, cfg_ready}, 32'd1);
    run_ch(0, 10, 0, 20);

    // Channel 1 was loaded with 8 while disabled.
    en = 4'b0010;
    step();
    run_ch(1, 8, 0, 16);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd1;
    cfg_period = 16'd4;
    run_ch(1, 8, 0, 3);
    cfg_valid = 1'b0;
    #1 check_eq("rdy_ch1_pend", {31'd0, cfg_ready}, 32'd0);
    en = 4'b0000;
    step();
    check_eq("rdy_drop", {31'd0, cfg_ready}, 32'd1);
    check_eq("off_out", {24'd0, tick, clk_out}, 32'd0);
    en = 4'b0010;
    step();
    run_ch(1, 4, 0, 8);

    // Channel 2 loaded with 5 on the same edge it is enabled.
    en         = 4'b0100;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd2;
    cfg_period = 16'd5;
    step();
    cfg_valid = 1'b0;
    run_ch(2, 5, 0, 10);

    // Illegal periods are rejected and leave the channel untouched.
    cfg_valid  = 1'b1;
    cfg_period = 16'd1;
    run_ch(2, 5, 0, 1);
    check_eq("err_p1", {31'd0, cfg_err}, 32'd1);
    cfg_period = 16'd0;
    run_ch(2, 5, 1, 1);
    check_eq("err_p0", {31'd0, cfg_err}, 32'd1);
    cfg_valid = 1'b0;
    run_ch(2, 5, 2, 1);
    check_eq("err_clr", {31'd0, cfg_err}, 32'd0);
    cfg3_valid = 1'b1;
    cfg3_ch    = 2'd3;
    #1 check_eq("rdy3_oor", {31'd0, ready3}, 32'd1);
    run_ch(2, 5, 3, 1);
    check_eq("err3_oor", {31'd0, err3}, 32'd1);
    cfg3_valid = 1'b0;
    run_ch(2, 5, 4, 1);
    check_eq("err3_clr", {31'd0, err3}, 32'd0);
    check_eq("ch3_idle", {26'd0, tick3, clk_out3}, 32'd0);
    run_ch(2, 5, 0, 10);

    // Reset mid high phase with a pending write.
    cfg_valid  = 1'b1;
    cfg_period = 16'd7;
    run_ch(2, 5, 0, 1);
    cfg_valid = 1'b0;
    #1 check_eq("rdy_ch2_pend", {31'd0, cfg_ready}, 32'd0);
    check_eq("pre_rst_high", {28'd0, clk_out}, 32'd4);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_out", {24'd0, tick, clk_out}, 32'd0);
    check_eq("rst_async_rdy", {31'd0, cfg_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_ch(2, 50, 0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
